// File: rtl/otter_pkg.sv
// Shared OTTER core definitions.
// Interrupt sequencer state, trap vector alignment and CSR addresses.
package otter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAKE = 2'd1,
        HOLD = 2'd2
    } intr_state_t;

    localparam logic [31:0] MTVEC_ALIGN_MASK = 32'hFFFF_FFFC;

    localparam logic [11:0] CSR_MSTATUS_ADDR = 12'h300;
    localparam logic [11:0] CSR_MIE_ADDR     = 12'h304;
    localparam logic [11:0] CSR_MTVEC_ADDR   = 12'h305;
    localparam logic [11:0] CSR_MEPC_ADDR    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE_ADDR  = 12'h342;

    function automatic logic [31:0] align_mtvec(input logic [31:0] vec);
        return vec & MTVEC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Reusable for any async line entering the CLK domain.
module sync2 (
    input  logic CLK,
    input  logic RST_N,
    input  logic async_in,
    output logic sync_out
);

    logic s1;

    // Two back-to-back flops to settle metastability
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1       <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            s1       <= async_in;
            sync_out <= s1;
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt sequencer upstream of the CSR block.
// Latches INTR, enters the trap at a clean boundary and redirects on mret.
module intr_ctrl
    import otter_pkg::*;
#(
    parameter bit EDGE_TRIG   = 1'b1,
    parameter int HOLD_CYCLES = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        INTR,
    input  logic        CSR_MSTATUS_MIE,
    input  logic [31:0] CSR_MTVEC,
    input  logic [31:0] CSR_MEPC,
    input  logic        MRET_EXEC,
    input  logic        RESUME_VALID,
    input  logic [31:0] RESUME_PC,
    input  logic        STALL,
    output logic        INT_TAKEN,
    output logic [31:0] INT_PC,
    output logic        MRET_OUT,
    output logic        FLUSH,
    output logic        REDIRECT,
    output logic [31:0] REDIRECT_PC,
    output logic        INT_PENDING
);

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    intr_state_t state;
    intr_state_t state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        s2;
    logic        d;
    logic        take_go;
    logic        mret_go;

    sync2 u_sync (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .async_in (INTR),
        .sync_out (s2)
    );

    // Edge-detect delay flop and pending latch; a new edge beats the take clear
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            d           <= 1'b0;
            INT_PENDING <= 1'b0;
        end else begin
            d <= s2;
            if (EDGE_TRIG)
                INT_PENDING <= (s2 & ~d) | (INT_PENDING & ~take_go);
            else
                INT_PENDING <= s2;
        end
    end

    // State and hold counter registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; mret in IDLE outranks an eligible interrupt
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        take_go   = 1'b0;
        mret_go   = 1'b0;
        unique case (state)
            IDLE: begin
                mret_go = MRET_EXEC;
                take_go = INT_PENDING & CSR_MSTATUS_MIE & RESUME_VALID
                          & ~STALL & ~MRET_EXEC;
                if (take_go)
                    state_nxt = TAKE;
            end
            TAKE: begin
                state_nxt = HOLD;
                cnt_nxt   = HOLD_LOAD;
            end
            HOLD: begin
                if (cnt == 4'd0)
                    state_nxt = IDLE;
                else
                    cnt_nxt = cnt - 4'd1;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Registered CSR and fetch outputs; INT_PC holds the saved epc until next take
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            INT_TAKEN   <= 1'b0;
            INT_PC      <= 32'd0;
            MRET_OUT    <= 1'b0;
            FLUSH       <= 1'b0;
            REDIRECT    <= 1'b0;
            REDIRECT_PC <= 32'd0;
        end else begin
            INT_TAKEN <= take_go;
            MRET_OUT  <= mret_go;
            FLUSH     <= take_go | mret_go;
            REDIRECT  <= take_go | mret_go;
            if (take_go) begin
                INT_PC      <= RESUME_PC;
                REDIRECT_PC <= align_mtvec(CSR_MTVEC);
            end else if (mret_go) begin
                REDIRECT_PC <= CSR_MEPC;
            end
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl with a scoreboard of expected
// trap-entry and mret events.
module tb_intr_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        INTR;
    logic        CSR_MSTATUS_MIE;
    logic [31:0] CSR_MTVEC;
    logic [31:0] CSR_MEPC;
    logic        MRET_EXEC;
    logic        RESUME_VALID;
    logic [31:0] RESUME_PC;
    logic        STALL;
    logic        INT_TAKEN;
    logic [31:0] INT_PC;
    logic        MRET_OUT;
    logic        FLUSH;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        INT_PENDING;

    int vectors = 0;
    int errs    = 0;

    typedef struct {
        string       tag;
        logic        intk;
        logic        mret;
        logic [31:0] rpc;
        logic [31:0] ipc;
    } exp_t;

    exp_t sb[$];

    intr_ctrl #(.EDGE_TRIG(1'b1), .HOLD_CYCLES(3)) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .INTR            (INTR),
        .CSR_MSTATUS_MIE (CSR_MSTATUS_MIE),
        .CSR_MTVEC       (CSR_MTVEC),
        .CSR_MEPC        (CSR_MEPC),
        .MRET_EXEC       (MRET_EXEC),
        .RESUME_VALID    (RESUME_VALID),
        .RESUME_PC       (RESUME_PC),
        .STALL           (STALL),
        .INT_TAKEN       (INT_TAKEN),
        .INT_PC          (INT_PC),
        .MRET_OUT        (MRET_OUT),
        .FLUSH           (FLUSH),
        .REDIRECT        (REDIRECT),
        .REDIRECT_PC     (REDIRECT_PC),
        .INT_PENDING     (INT_PENDING)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic intk, input logic mret,
                        input logic [31:0] rpc, input logic [31:0] ipc);
        exp_t e;
        e.tag  = tag;
        e.intk = intk;
        e.mret = mret;
        e.rpc  = rpc;
        e.ipc  = ipc;
        sb.push_back(e);
    endtask

    // Wait (bounded) for a take or mret pulse, then check it against the queue head
    task automatic expect_event(input string tag, input int max);
        int   n;
        logic seen;
        exp_t e;
        n = 0;
        while (!(INT_TAKEN || MRET_OUT) && n < max) begin
            @(negedge CLK);
            n++;
        end
        seen = INT_TAKEN | MRET_OUT;
        chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (seen) begin
                chk({e.tag, "_taken"}, {31'd0, INT_TAKEN}, {31'd0, e.intk});
                chk({e.tag, "_mret"}, {31'd0, MRET_OUT}, {31'd0, e.mret});
                chk({e.tag, "_flush"}, {31'd0, FLUSH}, 32'd1);
                chk({e.tag, "_redir"}, {31'd0, REDIRECT}, 32'd1);
                chk({e.tag, "_rpc"}, REDIRECT_PC, e.rpc);
                if (e.intk)
                    chk({e.tag, "_ipc"}, INT_PC, e.ipc);
            end
        end
    endtask

    task automatic pulse_intr();
        INTR = 1'b1;
        repeat (2) @(negedge CLK);
        INTR = 1'b0;
    endtask

    initial begin
        RST_N           = 1'b0;
        INTR            = 1'b1;
        CSR_MSTATUS_MIE = 1'b0;
        CSR_MTVEC       = 32'd0;
        CSR_MEPC        = 32'd0;
        MRET_EXEC       = 1'b0;
        RESUME_VALID    = 1'b0;
        RESUME_PC       = 32'd0;
        STALL           = 1'b0;

        // Reset with INTR held high
        repeat (3) @(negedge CLK);
        chk("rst_taken", {31'd0, INT_TAKEN}, 32'd0);
        chk("rst_flush", {31'd0, FLUSH}, 32'd0);
        chk("rst_redir", {31'd0, REDIRECT}, 32'd0);
        chk("rst_mret", {31'd0, MRET_OUT}, 32'd0);
        chk("rst_rpc", REDIRECT_PC, 32'd0);
        chk("rst_ipc", INT_PC, 32'd0);
        chk("rst_pend", {31'd0, INT_PENDING}, 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("sync_e1", {31'd0, INT_PENDING}, 32'd0);
        @(negedge CLK);
        chk("sync_e2", {31'd0, INT_PENDING}, 32'd0);
        @(negedge CLK);
        chk("sync_e3", {31'd0, INT_PENDING}, 32'd1);
        INTR  = 1'b0;
        RST_N = 1'b0;
        @(negedge CLK);
        chk("rst_clr_pend", {31'd0, INT_PENDING}, 32'd0);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);

        // Basic entry
        CSR_MSTATUS_MIE = 1'b1;
        CSR_MTVEC       = 32'h0000_0103;
        RESUME_PC       = 32'h0000_0040;
        RESUME_VALID    = 1'b1;
        push("basic", 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0040);
        pulse_intr();
        expect_event("basic", 6);
        @(negedge CLK);
        CSR_MSTATUS_MIE = 1'b0;
        chk("basic_taken_1cy", {31'd0, INT_TAKEN}, 32'd0);
        chk("basic_flush_1cy", {31'd0, FLUSH}, 32'd0);
        chk("basic_redir_1cy", {31'd0, REDIRECT}, 32'd0);
        chk("basic_pend_clr", {31'd0, INT_PENDING}, 32'd0);
        chk("basic_ipc_hold", INT_PC, 32'h0000_0040);
        repeat (5) @(negedge CLK);

        // Masked: pending held while MIE=0
        pulse_intr();
        repeat (3) @(negedge CLK);
        chk("mask_pend", {31'd0, INT_PENDING}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("mask_no_take", {31'd0, INT_TAKEN}, 32'd0);
        end
        chk("mask_pend_kept", {31'd0, INT_PENDING}, 32'd1);
        CSR_MSTATUS_MIE = 1'b1;
        RESUME_PC       = 32'h0000_0044;
        push("mask", 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0044);
        expect_event("mask", 1);
        @(negedge CLK);
        CSR_MSTATUS_MIE = 1'b0;
        repeat (5) @(negedge CLK);

        // MRET and eligible interrupt in the same cycle
        pulse_intr();
        repeat (3) @(negedge CLK);
        chk("coll_pend", {31'd0, INT_PENDING}, 32'd1);
        CSR_MSTATUS_MIE = 1'b1;
        MRET_EXEC       = 1'b1;
        CSR_MEPC        = 32'h0000_0200;
        RESUME_PC       = 32'h0000_0048;
        push("coll_mret", 1'b0, 1'b1, 32'h0000_0200, 32'd0);
        push("coll_int", 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0048);
        @(posedge CLK);
        #1 MRET_EXEC = 1'b0;
        @(negedge CLK);
        expect_event("coll_mret", 2);
        @(negedge CLK);
        chk("coll_mret_1cy", {31'd0, MRET_OUT}, 32'd0);
        expect_event("coll_int", 1);
        @(negedge CLK);
        CSR_MSTATUS_MIE = 1'b0;
        chk("coll_taken_1cy", {31'd0, INT_TAKEN}, 32'd0);
        repeat (5) @(negedge CLK);

        // Deferral by STALL then by RESUME_VALID=0
        STALL           = 1'b1;
        CSR_MSTATUS_MIE = 1'b1;
        RESUME_PC       = 32'h0000_0050;
        pulse_intr();
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("stall_no_take", {31'd0, INT_TAKEN}, 32'd0);
            chk("stall_pend", {31'd0, INT_PENDING}, 32'd1);
        end
        STALL        = 1'b0;
        RESUME_VALID = 1'b0;
        RESUME_PC    = 32'h0000_0054;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("rv_no_take", {31'd0, INT_TAKEN}, 32'd0);
        end
        RESUME_VALID = 1'b1;
        RESUME_PC    = 32'h0000_0058;
        push("defer", 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0058);
        expect_event("defer", 1);
        @(negedge CLK);
        CSR_MSTATUS_MIE = 1'b0;
        repeat (5) @(negedge CLK);

        // Second edge during HOLD is deferred until HOLD ends
        CSR_MSTATUS_MIE = 1'b1;
        CSR_MTVEC       = 32'h0000_0203;
        RESUME_PC       = 32'h0000_0060;
        push("hold1", 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0060);
        pulse_intr();
        expect_event("hold1", 6);
        INTR      = 1'b1;
        RESUME_PC = 32'h0000_0064;
        push("hold2", 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0064);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("hold_no_take", {31'd0, INT_TAKEN}, 32'd0);
            if (i == 1)
                INTR = 1'b0;
        end
        expect_event("hold2", 1);
        @(negedge CLK);
        CSR_MSTATUS_MIE = 1'b0;
        repeat (5) @(negedge CLK);

        // Reset asserted during TAKE
        CSR_MSTATUS_MIE = 1'b1;
        RESUME_PC       = 32'h0000_0070;
        push("rst_take", 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0070);
        pulse_intr();
        expect_event("rst_take", 6);
        #2 RST_N = 1'b0;
        #1;
        chk("mid_rst_taken", {31'd0, INT_TAKEN}, 32'd0);
        chk("mid_rst_flush", {31'd0, FLUSH}, 32'd0);
        chk("mid_rst_redir", {31'd0, REDIRECT}, 32'd0);
        chk("mid_rst_rpc", REDIRECT_PC, 32'd0);
        chk("mid_rst_ipc", INT_PC, 32'd0);
        chk("mid_rst_pend", {31'd0, INT_PENDING}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("post_rst_idle", {31'd0, INT_TAKEN}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
